// File: rtl/bcd_counter.sv
// bcd_counter: one decimal digit of a runtime-programmable modulo-N counter.
// It is a building block for a real-time-clock datapath. A downstream digit
// uses ov as its count enable, so digits can be chained.
//
// Ports:
//   clk   - system clock; all state changes on the rising edge
//   rset  - synchronous, active-high reset; takes priority over counting
//   mode  - modulus select. Values 2..10 select modulo-mode.
//           Values 0 and 1 hold the count at 0.
//           Values 11..15 are clamped to modulo-10.
//   count - registered digit value, always in 0..9
//   ov    - terminal-count flag, combinational; forced low during reset
module bcd_counter (
  input  logic       clk,
  input  logic       rset,
  input  logic [3:0] mode,
  output logic [3:0] count,
  output logic       ov
);

  logic [3:0] count_q, count_d;
  logic [3:0] last_w;   // effective modulus minus one
  logic       term_w;

  // Map mode onto the last legal count value. An illegal low mode acts as
  // modulo-1, so the count is pinned at 0. An illegal high mode is clamped
  // to BCD.
  always_comb begin
    last_w = 4'd9;
    if (mode < 4'd2)        last_w = 4'd0;
    else if (mode <= 4'd10) last_w = mode - 4'd1;
  end

  // Use >= rather than == so that a count left above range by a mode
  // change still raises ov. The next edge then wraps it back to 0.
  assign term_w  = (count_q >= last_w);
  assign count_d = term_w ? 4'd0 : count_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rset) count_q <= 4'd0;
    else      count_q <= count_d;
  end

  // Use a ternary on rset so that ov stays a clean 0 even when mode is
  // unknown during reset.
  assign ov    = rset ? 1'b0 : term_w;
  assign count = count_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Testbench for bcd_counter. It runs the directed sequences first and then
// randomized mode and reset traffic. Every result is checked against an
// arithmetic model of the modulo-M rules.
module tb_bcd_counter;

  logic       clk = 1'b0;
  logic       rset;
  logic [3:0] mode;
  logic [3:0] count;
  logic       ov;

  int n_chk  = 0;
  int n_fail = 0;
  int mcnt   = -1;   // model count; -1 = unknown before first reset
  int ov_hits = 0;

  bcd_counter dut (
    .clk   (clk),
    .rset  (rset),
    .mode  (mode),
    .count (count),
    .ov    (ov)
  );

  always #5 clk = ~clk;

  // Effective modulus M as defined by the mode rules.
  function automatic int eff_mod(input logic [3:0] m);
    int v;
    v = int'(m);
    if (v < 2)  return 1;
    if (v > 10) return 10;
    return v;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven just after the falling edge. Outputs are checked 1ns
  // later, which is well before the next rising edge. The model then
  // advances over that edge.
  task automatic step(input logic r, input logic [3:0] m);
    int exp_ov;
    rset = r;
    mode = m;
    #1;
    if (r) exp_ov = 0;
    else   exp_ov = (mcnt >= eff_mod(m) - 1) ? 1 : 0;
    if (mcnt >= 0) begin
      chk("count", int'(count), mcnt);
      chk("range", (count <= 4'd9) ? 1 : 0, 1);
    end
    chk("ov", int'(ov), exp_ov);
    if (ov === 1'b1) ov_hits++;
    @(posedge clk);
    if (r)                             mcnt = 0;
    else if (mcnt >= eff_mod(m) - 1)   mcnt = 0;
    else                               mcnt = mcnt + 1;
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) step(1'b0, m);
  endtask

  initial begin
    logic [3:0] rm;
    rset = 1'b1;
    mode = 4'bxxxx;
    @(negedge clk);

    // Reset with an unknown mode.
    step(1'b1, 4'bxxxx);
    step(1'b1, 4'bxxxx);

    run(4'd2, 6);
    run(4'd3, 6);
    run(4'd4, 8);
    run(4'd6, 12);

    // Modulo-10 over 20 cycles: ov should be seen on exactly two of them.
    ov_hits = 0;
    run(4'd10, 20);
    chk("ov_hits_mod10", ov_hits, 2);

    // Move to count 7, then switch down to modulo-4.
    run(4'd10, 7);
    run(4'd4, 6);

    // Reset in the middle of a count at 5 under modulo-6.
    step(1'b1, 4'd6);
    run(4'd6, 5);
    step(1'b1, 4'd6);
    run(4'd6, 3);

    // Illegal low mode holds the count at 0; illegal high mode acts as
    // modulo-10.
    run(4'd0, 4);
    run(4'd1, 2);
    run(4'd15, 12);

    // Random traffic. Mode changes occasionally and reset is rare.
    rm = 4'd10;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rm = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, rm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety bound so that a stall in the run cannot hang the simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
